// File: rtl/popcount22_vecgen_pkg.sv
// Shared constants, state encoding and helpers for the popcount22 vector generator.
package popcount22_vecgen_pkg;

  localparam int N  = 22;
  localparam int CW = 5;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Bits [kc-1:0] set; kc=0 gives zero, kc=N gives all ones.
  function automatic logic [N-1:0] thermo(input logic [CW-1:0] kc);
    return ~({N{1'b1}} << kc);
  endfunction

  // r never exceeds 31 < 2N, so one conditional subtraction reduces it mod N.
  function automatic logic [CW-1:0] mod_n(input logic [CW-1:0] r);
    return (r >= CW'(N)) ? (r - CW'(N)) : r;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/popcount22_vecgen_if.sv
// Request/response bundle between a stimulus consumer and the vector generator.
interface popcount22_vecgen_if;
  import popcount22_vecgen_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          rot_mode;
  logic [CW-1:0] rot_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic [CW-1:0] out_count;
  logic          out_sat;

  modport master (
    output in_valid, in_count, rot_mode, rot_in, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_count, rot_mode, rot_in, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_sat
  );

endinterface

// File: rtl/popcount22_vecgen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift), advanced every cycle outside reset.
module popcount22_vecgen_lfsr16
  import popcount22_vecgen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic [15:0] state_r;

  // LFSR register; SEED must be nonzero or the sequence locks up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SEED;
    end else begin
      state_r <= lfsr_next(state_r);
    end
  end

  assign state = state_r;

endmodule

// File: rtl/popcount22_vecgen.sv
// Emits a 22-bit vector with exactly min(K,22) ones: a thermometer code rotated
// left one bit per cycle by a fixed or LFSR-chosen amount.
module popcount22_vecgen
  import popcount22_vecgen_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  popcount22_vecgen_if.slave  bus
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  shreg_r;
  logic [CW-1:0] rot_cnt_r;
  logic [CW-1:0] out_count_r;
  logic          out_sat_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [15:0]   lfsr_s;
  logic          unused_lfsr_s;
  logic          accept_s;
  logic          sat_s;
  logic [CW-1:0] kc_s;
  logic [CW-1:0] rot_sel_s;

  popcount22_vecgen_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:CW];

  // Request decode: clamp the count and pick the raw rotation source.
  always_comb begin
    accept_s  = bus.in_valid & in_ready_r;
    sat_s     = (bus.in_count > CW'(N));
    kc_s      = sat_s ? CW'(N) : bus.in_count;
    rot_sel_s = bus.rot_mode ? bus.rot_in : lfsr_s[CW-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = ROT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ROT: begin
        if (rot_cnt_r == {CW{1'b0}}) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = ROT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, handshake flags and datapath registers; reset drops any in-flight vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      shreg_r     <= {N{1'b0}};
      rot_cnt_r   <= {CW{1'b0}};
      out_count_r <= {CW{1'b0}};
      out_sat_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == OUT);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shreg_r     <= thermo(kc_s);
            rot_cnt_r   <= mod_n(rot_sel_s);
            out_count_r <= kc_s;
            out_sat_r   <= sat_s;
          end
        end
        ROT: begin
          if (rot_cnt_r != {CW{1'b0}}) begin
            shreg_r   <= {shreg_r[N-2:0], shreg_r[N-1]};
            rot_cnt_r <= rot_cnt_r - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vec   = shreg_r;
  assign bus.out_count = out_count_r;
  assign bus.out_sat   = out_sat_r;

endmodule
